// File: rtl/grf_wb_queue.sv
// ---------------------------------------------------------------------------
// grf_wb_queue
//
// Writeback queue between the result producers and the single GRF write port.
// Producers push register writes through a valid/ready handshake. The writes
// sit in an in-order FIFO and drain one per cycle into the GRF (WE/A3/WD/PC).
// Two lookup ports let decode find and forward values that are still pending
// in the queue.
//
// Handshake: a request is taken on a rising edge where in_valid && in_ready.
// in_ready is !full and comes only from registered state. Writes to $0 still
// complete the handshake, but they are dropped and never reach the GRF.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low clear of all state
//   in_valid/in_ready   producer handshake
//   in_addr/data/pc     destination register, value, producing PC
//   drain_en            1 allows the head entry to be written this cycle
//   grf_we/a3/wd/pc     GRF write port, driven from the head entry
//   look_a1/a2          register numbers read by decode
//   look_hit1/2         a pending write to that register exists
//   look_data1/2        value of the youngest pending write, 0 if no hit
//   count               number of valid entries
// ---------------------------------------------------------------------------
module grf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [31:0]              in_data,
    input  logic [31:0]              in_pc,
    input  logic                     drain_en,
    output logic                     grf_we,
    output logic [4:0]               grf_a3,
    output logic [31:0]              grf_wd,
    output logic [31:0]              grf_pc,
    input  logic [4:0]               look_a1,
    input  logic [4:0]               look_a2,
    output logic                     look_hit1,
    output logic                     look_hit2,
    output logic [31:0]              look_data1,
    output logic [31:0]              look_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic push;
    logic pop;
    logic empty;

    assign empty    = (cnt == '0);
    assign in_ready = (cnt != CW'(DEPTH));
    assign grf_we   = !empty && drain_en;
    assign pop      = grf_we;
    // A $0 write is acknowledged but does not occupy an entry.
    assign push     = in_valid && in_ready && (in_addr != 5'd0);
    assign count    = cnt;

    // The head is masked when the queue is empty. Popped slots keep stale
    // contents and must not show on the write port.
    always_comb begin
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (!empty) begin
            grf_a3 = addr_q[rd_ptr];
            grf_wd = data_q[rd_ptr];
            grf_pc = pc_q[rd_ptr];
        end
    end

    // The search goes from oldest (offset 0 from rd_ptr) to youngest. A later
    // match overrides an earlier one, so the youngest write wins. The head is
    // included even while it is being written to the GRF this cycle.
    function automatic logic [32:0] lookup(input logic [4:0] a);
        logic [32:0]   r;
        logic [AW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((CW'(i) < cnt) && (a != 5'd0) && (addr_q[idx] == a)) begin
                r = {1'b1, data_q[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {look_hit1, look_data1} = lookup(look_a1);
        {look_hit2, look_data2} = lookup(look_a2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= in_addr;
                data_q[wr_ptr] <= in_data;
                pc_q[wr_ptr]   <= in_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_grf_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_grf_wb_queue
//
// Directed bench for grf_wb_queue. A queue-based model of the writeback FIFO
// predicts every output. A compare process checks the outputs against the
// model on each falling edge. Literal expectations in the directed sequence
// pin the model itself.
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_grf_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [31:0]   in_data;
    logic [31:0]   in_pc;
    logic          drain_en;
    logic          grf_we;
    logic [4:0]    grf_a3;
    logic [31:0]   grf_wd;
    logic [31:0]   grf_pc;
    logic [4:0]    look_a1;
    logic [4:0]    look_a2;
    logic          look_hit1;
    logic          look_hit2;
    logic [31:0]   look_data1;
    logic [31:0]   look_data2;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    grf_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_pc      (in_pc),
        .drain_en   (drain_en),
        .grf_we     (grf_we),
        .grf_a3     (grf_a3),
        .grf_wd     (grf_wd),
        .grf_pc     (grf_pc),
        .look_a1    (look_a1),
        .look_a2    (look_a2),
        .look_hit1  (look_hit1),
        .look_hit2  (look_hit2),
        .look_data1 (look_data1),
        .look_data2 (look_data2),
        .count      (count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t mq[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            bit can_take;
            can_take = (mq.size() != DEPTH);
            if (mq.size() != 0 && drain_en) void'(mq.pop_front());
            if (in_valid && can_take && in_addr != 5'd0)
                mq.push_back('{a: in_addr, d: in_data, p: in_pc});
        end
    end

    function automatic logic [32:0] model_look(input logic [4:0] a);
        if (a == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == a) return {1'b1, mq[i].d};
        return '0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] l1, l2;
        ent_t        h;
        l1 = model_look(look_a1);
        l2 = model_look(look_a2);
        h  = (mq.size() != 0) ? mq[0] : '0;
        check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        check("m_count",    32'(count),    32'(mq.size()));
        check("m_grf_we",   32'(grf_we),   32'(mq.size() != 0 && drain_en));
        check("m_grf_a3",   32'(grf_a3),   32'(h.a));
        check("m_grf_wd",   grf_wd,        h.d);
        check("m_grf_pc",   grf_pc,        h.p);
        check("m_hit1",     32'(look_hit1), 32'(l1[32]));
        check("m_data1",    look_data1,    l1[31:0]);
        check("m_hit2",     32'(look_hit2), 32'(l2[32]));
        check("m_data2",    look_data2,    l2[31:0]);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_pc    = p;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        in_pc    = '0;
        drain_en = 1'b0;
        look_a1  = '0;
        look_a2  = '0;
        #1 reset = 1'b0;
        #22;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count",    32'(count),    32'd0);
        check("rst_grf_we",   32'(grf_we),   32'd0);
        reset = 1'b1;
        tick();

        // Single write
        drain_en = 1'b1;
        push(5'd5, 32'h1234, 32'h3000);
        #4;
        check("t1_we",    32'(grf_we), 32'd1);
        check("t1_a3",    32'(grf_a3), 32'd5);
        check("t1_wd",    grf_wd,      32'h1234);
        check("t1_pc",    grf_pc,      32'h3000);
        check("t1_count", 32'(count),  32'd1);
        tick();
        #4;
        check("t1_count0", 32'(count), 32'd0);

        // Fill with drain disabled, then drain
        tick();
        drain_en = 1'b0;
        for (int a = 1; a <= 4; a++) push(5'(a), 32'h100 + a, 32'h4000 + 4 * a);
        #4;
        check("t2_count", 32'(count),    32'd4);
        check("t2_ready", 32'(in_ready), 32'd0);
        check("t2_we",    32'(grf_we),   32'd0);
        tick();
        drain_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #4;
            check("t2_dr_we",    32'(grf_we),   32'd1);
            check("t2_dr_a3",    32'(grf_a3),   32'(k));
            check("t2_dr_ready", 32'(in_ready), (k == 1) ? 32'd0 : 32'd1);
            tick();
        end
        #4;
        check("t2_empty", 32'(count), 32'd0);

        // $0 discard
        tick();
        look_a1  = 5'd0;
        in_valid = 1'b1;
        in_addr  = 5'd0;
        in_data  = 32'hFFFF;
        #4;
        check("t3_ready_during", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #4;
        check("t3_count", 32'(count),     32'd0);
        check("t3_we",    32'(grf_we),    32'd0);
        check("t3_hit",   32'(look_hit1), 32'd0);

        // Youngest-wins lookup
        tick();
        drain_en = 1'b0;
        push(5'd7, 32'hA, 32'h5000);
        push(5'd7, 32'hB, 32'h5004);
        look_a1 = 5'd7;
        look_a2 = 5'd7;
        #4;
        check("t4_hit",   32'(look_hit1), 32'd1);
        check("t4_data",  look_data1,     32'hB);
        check("t4_data2", look_data2,     32'hB);
        tick();
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        #4;
        check("t4_hit_d1",  32'(look_hit1), 32'd1);
        check("t4_data_d1", look_data1,     32'hB);
        tick();
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        #4;
        check("t4_hit_d2",  32'(look_hit1), 32'd0);
        check("t4_data_d2", look_data1,     32'd0);

        // Concurrent push/pop when full
        tick();
        for (int a = 8; a <= 11; a++) push(5'(a), 32'h200 + a, 32'h6000 + a);
        in_valid = 1'b1;
        in_addr  = 5'd12;
        in_data  = 32'h20C;
        in_pc    = 32'h600C;
        drain_en = 1'b1;
        #4;
        check("t5_ready_full", 32'(in_ready), 32'd0);
        check("t5_count_full", 32'(count),    32'd4);
        tick();
        #4;
        check("t5_count3", 32'(count),    32'd3);
        check("t5_ready",  32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #4;
        check("t5_count_keep", 32'(count),  32'd3);
        check("t5_head",       32'(grf_a3), 32'd10);
        repeat (3) tick();
        #4;
        check("t5_empty", 32'(count), 32'd0);

        // Async reset mid-operation
        tick();
        drain_en = 1'b0;
        push(5'd20, 32'h300, 32'h7000);
        push(5'd21, 32'h301, 32'h7004);
        push(5'd22, 32'h302, 32'h7008);
        look_a1  = 5'd21;
        drain_en = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("t6_we",    32'(grf_we),    32'd0);
        check("t6_count", 32'(count),     32'd0);
        check("t6_hit",   32'(look_hit1), 32'd0);
        check("t6_ready", 32'(in_ready),  32'd1);
        check("t6_a3",    32'(grf_a3),    32'd0);
        #4 reset = 1'b1;
        repeat (3) begin
            tick();
            #4;
            check("t6_no_stale", 32'(grf_we), 32'd0);
        end

        // Mixed stream: model-checked every cycle
        tick();
        for (int i = 0; i < 60; i++) begin
            in_valid = (i % 3 != 2);
            in_addr  = 5'((i * 7) % 32);
            in_data  = 32'hC000 + i;
            in_pc    = 32'h8000 + 4 * i;
            drain_en = (i % 5 != 0) && (i < 20 || i > 30);
            look_a1  = 5'((i * 3) % 32);
            look_a2  = in_addr;
            tick();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        repeat (6) tick();
        #4;
        check("end_empty", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_wb_queue.md
# grf_wb_queue

Writeback queue sitting between the result producers (ALU, load path, multiply/divide unit) and the GRF write port. Accepts register-write requests over a valid/ready handshake, buffers them in a small in-order FIFO, and drains one request per cycle into the GRF's single write port (WE/A3/WD/PC). Provides two lookup ports so decode can detect and forward values still pending in the queue.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- in_valid  in  1  producer has a write request this cycle
- in_ready  out  1  queue can accept; equals !full
- in_addr  in  5  destination register number
- in_data  in  32  value to write
- in_pc  in  32  PC of the producing instruction, carried for the GRF trace print
- drain_en  in  1  1 = head may be written to GRF this cycle; 0 freezes draining
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address (head entry)
- grf_wd  out  32  GRF write data (head entry)
- grf_pc  out  32  PC of head entry
- look_a1, look_a2  in  5 each  register numbers being read by decode
- look_hit1, look_hit2  out  1 each  a pending write to that register is in the queue
- look_data1, look_data2  out  32 each  value of the youngest pending write to that register; 0 when no hit
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {addr, data, pc}, write pointer, read pointer, count; pointers wrap modulo DEPTH.
- Accept: handshake completes on a rising edge with in_valid && in_ready.
- in_addr == 0: handshake completes, nothing enqueued, count unchanged ($0 writes are discarded here; the GRF never sees them).
- in_addr != 0: entry written at write pointer, pointer advances.
- in_ready = (count != DEPTH); depends only on registered state, never on in_valid or drain_en.
- Drain: grf_we = (count != 0) && drain_en, combinational. grf_a3/grf_wd/grf_pc always show the head entry, all zero when empty. On an edge with grf_we = 1 the GRF captures the head and the read pointer advances.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into a full queue is impossible (in_ready = 0), even when a pop occurs the same edge.
- Order: strictly FIFO; two writes to the same register reach the GRF in acceptance order.
- Lookup: combinational search of all valid entries, including the head being written this cycle. Several matches: youngest (closest to write pointer) wins. look_aN == 0: never hits. Entries not yet accepted (in_valid with in_ready low) are not visible.
- Reset (reset = 0): count, pointers and all entry fields cleared asynchronously; grf_we = 0, in_ready = 1, look_hitN = 0, all data outputs 0. Requests in flight are lost; no partial write reaches the GRF.

## Timing
- Latency: request accepted at edge N into an empty queue with drain_en = 1 -> grf_we = 1 during cycle N..N+1, GRF written at edge N+1.
- Throughput: one accept and one drain per cycle sustained; the queue never fills while drain_en stays 1.
- Lookup results are valid in the same cycle as look_aN changes (pure combinational from addresses and state).
- drain_en low for k cycles delays every pending write by exactly k cycles; contents and order are preserved.
- Reset deassertion: first accept possible at the first rising edge after reset returns to 1.

## Test plan
- Single write: reset, push {addr=5, data=0x1234, pc=0x3000} -> next cycle grf_we=1, grf_a3=5, grf_wd=0x1234, grf_pc=0x3000; count returns to 0 after that edge.
- Fill with drain_en=0: push addr 1..4 (DEPTH=4) -> count=4, in_ready=0; raise drain_en -> GRF writes regs 1,2,3,4 on 4 consecutive edges, in_ready=1 after the first of them.
- $0 discard: push addr=0 data=0xFFFF -> in_ready stays 1, count stays 0, grf_we never asserted, look_hit1=0 for look_a1=0.
- Youngest-wins lookup: drain_en=0, push r7=0xA then r7=0xB -> look_a1=7 gives hit=1, data=0xB; after one drain the value is still 0xB; after two drains hit=0.
- Concurrent push/pop when full: count=4, drain_en=1, in_valid=1 -> push refused (in_ready=0), count=3 after the edge, push accepted the next edge.
- Async reset mid-operation: 3 entries queued, pull reset low between edges -> grf_we, count and look_hit drop to 0 immediately; after release, no stale writes appear.
